// File: rtl/arm7tdmi_pkg.sv
// Shared types, constants and mode helpers for the ARM7TDMI banked register file.
package arm7tdmi_pkg;

    localparam int unsigned PHYS_GPR_COUNT = 31;
    localparam int unsigned PHYS_W         = 5;
    localparam int unsigned SPSR_COUNT     = 5;
    localparam int unsigned SPSR_W         = 3;

    typedef logic [PHYS_W-1:0] phys_reg_t;
    typedef logic [SPSR_W-1:0] spsr_idx_t;

    localparam logic [31:0] RESET_CPSR = 32'h0000_00D3;
    localparam phys_reg_t   PHYS_PC    = 5'd15;

    localparam logic [3:0] PSR_F = 4'b1000;
    localparam logic [3:0] PSR_S = 4'b0100;
    localparam logic [3:0] PSR_X = 4'b0010;
    localparam logic [3:0] PSR_C = 4'b0001;

    localparam int unsigned CPSR_I = 7;
    localparam int unsigned CPSR_F = 6;
    localparam int unsigned CPSR_T = 5;

    typedef enum logic [4:0] {
        MODE_USR = 5'b10000,
        MODE_FIQ = 5'b10001,
        MODE_IRQ = 5'b10010,
        MODE_SVC = 5'b10011,
        MODE_ABT = 5'b10111,
        MODE_UND = 5'b11011,
        MODE_SYS = 5'b11111
    } mode_e;

    function automatic logic mode_is_valid(input logic [4:0] m);
        case (m)
            MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
            MODE_ABT, MODE_UND, MODE_SYS: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    function automatic logic mode_has_spsr(input logic [4:0] m);
        case (m)
            MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_ABT, MODE_UND: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    function automatic spsr_idx_t mode_spsr_idx(input logic [4:0] m);
        case (m)
            MODE_FIQ: return 3'd0;
            MODE_IRQ: return 3'd1;
            MODE_SVC: return 3'd2;
            MODE_ABT: return 3'd3;
            MODE_UND: return 3'd4;
            default:  return 3'd0;
        endcase
    endfunction

    // Byte-field merge for MSR; f_only restricts the update to the flags byte.
    function automatic logic [31:0] psr_merge(input logic [31:0] old_val,
                                              input logic [31:0] data,
                                              input logic [3:0]  mask,
                                              input logic        f_only);
        logic [31:0] res;
        res = old_val;
        if ((mask & PSR_F) != 4'b0) res[31:24] = data[31:24];
        if (!f_only) begin
            if ((mask & PSR_S) != 4'b0) res[23:16] = data[23:16];
            if ((mask & PSR_X) != 4'b0) res[15:8]  = data[15:8];
            if ((mask & PSR_C) != 4'b0) res[7:0]   = data[7:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/arm7tdmi_bank_map.sv
// Maps (mode, logical register, user-bank override) to a physical register index.
module arm7tdmi_bank_map
    import arm7tdmi_pkg::*;
(
    input  logic [4:0] mode,
    input  logic [3:0] idx,
    input  logic       user,
    output phys_reg_t  phys_c
);

    // Physical layout: 0-15 user r0-r15, 16-22 fiq r8-r14, then r13/r14 pairs irq, svc, abt, und.
    always_comb begin
        phys_c = phys_reg_t'(idx);
        if (!user) begin
            case (mode)
                MODE_FIQ: if (idx >= 4'd8 && idx <= 4'd14) phys_c = phys_reg_t'(idx) + 5'd8;
                MODE_IRQ: if (idx == 4'd13 || idx == 4'd14) phys_c = phys_reg_t'(idx) + 5'd10;
                MODE_SVC: if (idx == 4'd13 || idx == 4'd14) phys_c = phys_reg_t'(idx) + 5'd12;
                MODE_ABT: if (idx == 4'd13 || idx == 4'd14) phys_c = phys_reg_t'(idx) + 5'd14;
                MODE_UND: if (idx == 4'd13 || idx == 4'd14) phys_c = phys_reg_t'(idx) + 5'd16;
                default:  phys_c = phys_reg_t'(idx);
            endcase
        end
    end

endmodule

// File: rtl/arm7tdmi_banked_regfile.sv
// Mode-banked ARM7TDMI register file: GPRs, PC, CPSR and SPSRs with atomic exception entry.
module arm7tdmi_banked_regfile
    import arm7tdmi_pkg::*;
#(
    parameter int unsigned NUM_RD_PORTS = 3,
    parameter int unsigned NUM_WR_PORTS = 2,
    parameter bit          BYPASS       = 1'b1,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_RD_PORTS*4-1:0]   rd_addr,
    input  logic [NUM_RD_PORTS-1:0]     rd_user,
    output logic [NUM_RD_PORTS*32-1:0]  rd_data,
    input  logic [NUM_WR_PORTS-1:0]     wr_en,
    input  logic [NUM_WR_PORTS*4-1:0]   wr_addr,
    input  logic [NUM_WR_PORTS-1:0]     wr_user,
    input  logic [NUM_WR_PORTS*32-1:0]  wr_data,
    input  logic                        pc_inc,
    output logic [31:0]                 pc_o,
    input  logic                        cpsr_wr_en,
    input  logic [3:0]                  cpsr_wr_mask,
    input  logic [31:0]                 cpsr_wr_data,
    input  logic                        flags_wr_en,
    input  logic [3:0]                  flags_i,
    input  logic                        spsr_wr_en,
    input  logic [3:0]                  spsr_wr_mask,
    input  logic [31:0]                 spsr_wr_data,
    input  logic                        spsr_restore,
    input  logic                        exc_req,
    input  logic [4:0]                  exc_mode,
    input  logic [31:0]                 exc_vector,
    input  logic [31:0]                 exc_lr,
    input  logic                        exc_set_f,
    output logic [31:0]                 cpsr_o,
    output logic [31:0]                 spsr_o,
    output logic                        illegal_mode_o
);

    logic [31:0] gpr_q  [PHYS_GPR_COUNT];
    logic [31:0] gpr_d  [PHYS_GPR_COUNT];
    logic [31:0] spsr_q [SPSR_COUNT];
    logic [31:0] spsr_d [SPSR_COUNT];
    logic [31:0] cpsr_q, cpsr_d;
    logic        illegal_q, illegal_d;
    logic [31:0] cand;

    logic [4:0]  mode;
    logic        cur_has_spsr;
    spsr_idx_t   cur_sidx;
    spsr_idx_t   exc_sidx;
    logic        exc_ok;
    phys_reg_t   exc_lr_phys;
    phys_reg_t   wr_phys [NUM_WR_PORTS];

    assign mode         = cpsr_q[4:0];
    assign cur_has_spsr = mode_has_spsr(mode);
    assign cur_sidx     = mode_spsr_idx(mode);
    assign exc_sidx     = mode_spsr_idx(exc_mode);
    assign exc_ok       = exc_req && mode_has_spsr(exc_mode);

    for (genvar w = 0; w < NUM_WR_PORTS; w++) begin : g_wr_map
        arm7tdmi_bank_map u_map (
            .mode   (mode),
            .idx    (wr_addr[w*4 +: 4]),
            .user   (wr_user[w]),
            .phys_c (wr_phys[w])
        );
    end

    arm7tdmi_bank_map u_exc_lr_map (
        .mode   (exc_mode),
        .idx    (4'd14),
        .user   (1'b0),
        .phys_c (exc_lr_phys)
    );

    // Read ports; the highest matching write port is forwarded when bypass is enabled.
    for (genvar r = 0; r < NUM_RD_PORTS; r++) begin : g_rd
        phys_reg_t   phys;
        logic [31:0] word;

        arm7tdmi_bank_map u_map (
            .mode   (mode),
            .idx    (rd_addr[r*4 +: 4]),
            .user   (rd_user[r]),
            .phys_c (phys)
        );

        always_comb begin
            word = gpr_q[phys];
            if (BYPASS) begin
                for (int w = 0; w < int'(NUM_WR_PORTS); w++) begin
                    if (wr_en[w] && wr_phys[w] == phys) word = wr_data[w*32 +: 32];
                end
            end
        end

        assign rd_data[r*32 +: 32] = word;
    end

    always_comb begin
        gpr_d     = gpr_q;
        spsr_d    = spsr_q;
        cpsr_d    = cpsr_q;
        illegal_d = 1'b0;
        cand      = cpsr_q;

        if (pc_inc) gpr_d[PHYS_PC] = gpr_q[PHYS_PC] + (cpsr_q[CPSR_T] ? 32'd2 : 32'd4);

        for (int w = 0; w < int'(NUM_WR_PORTS); w++) begin
            if (wr_en[w]) gpr_d[wr_phys[w]] = wr_data[w*32 +: 32];
        end

        if (exc_req && !exc_ok) illegal_d = 1'b1;

        if (exc_ok) begin
            spsr_d[exc_sidx]   = cpsr_q;
            gpr_d[exc_lr_phys] = exc_lr;
            gpr_d[PHYS_PC]     = exc_vector;
            cpsr_d = {cpsr_q[31:8], 1'b1, cpsr_q[CPSR_F] | exc_set_f, 1'b0, exc_mode};
        end else begin
            if (spsr_restore && cur_has_spsr) begin
                cand = spsr_q[cur_sidx];
            end else begin
                if (cpsr_wr_en) cand = psr_merge(cpsr_q, cpsr_wr_data, cpsr_wr_mask, mode == MODE_USR);
                if (flags_wr_en) cand[31:28] = flags_i;
            end
            // An unencodable mode keeps the old mode field; the rest still lands.
            if (!mode_is_valid(cand[4:0])) begin
                cand[4:0] = cpsr_q[4:0];
                illegal_d = 1'b1;
            end
            cpsr_d = cand;
            if (spsr_wr_en && cur_has_spsr)
                spsr_d[cur_sidx] = psr_merge(spsr_q[cur_sidx], spsr_wr_data, spsr_wr_mask, 1'b0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(PHYS_GPR_COUNT); i++) gpr_q[i] <= '0;
            gpr_q[PHYS_PC] <= RESET_PC;
            for (int i = 0; i < int'(SPSR_COUNT); i++) spsr_q[i] <= '0;
            cpsr_q    <= RESET_CPSR;
            illegal_q <= 1'b0;
        end else begin
            gpr_q     <= gpr_d;
            spsr_q    <= spsr_d;
            cpsr_q    <= cpsr_d;
            illegal_q <= illegal_d;
        end
    end

    assign pc_o           = gpr_q[PHYS_PC];
    assign cpsr_o         = cpsr_q;
    assign spsr_o         = cur_has_spsr ? spsr_q[cur_sidx] : cpsr_q;
    assign illegal_mode_o = illegal_q;

endmodule

// File: tb/tb_arm7tdmi_banked_regfile.sv
// Directed self-checking bench for the banked register file.
module tb_arm7tdmi_banked_regfile;

    localparam int unsigned NRD = 3;
    localparam int unsigned NWR = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD*4-1:0]  rd_addr;
    logic [NRD-1:0]    rd_user;
    logic [NRD*32-1:0] rd_data;
    logic [NWR-1:0]    wr_en;
    logic [NWR*4-1:0]  wr_addr;
    logic [NWR-1:0]    wr_user;
    logic [NWR*32-1:0] wr_data;
    logic              pc_inc;
    logic [31:0]       pc_o;
    logic              cpsr_wr_en;
    logic [3:0]        cpsr_wr_mask;
    logic [31:0]       cpsr_wr_data;
    logic              flags_wr_en;
    logic [3:0]        flags_i;
    logic              spsr_wr_en;
    logic [3:0]        spsr_wr_mask;
    logic [31:0]       spsr_wr_data;
    logic              spsr_restore;
    logic              exc_req;
    logic [4:0]        exc_mode;
    logic [31:0]       exc_vector;
    logic [31:0]       exc_lr;
    logic              exc_set_f;
    logic [31:0]       cpsr_o;
    logic [31:0]       spsr_o;
    logic              illegal_mode_o;

    int n_vec = 0;
    int n_err = 0;

    arm7tdmi_banked_regfile #(
        .NUM_RD_PORTS (NRD),
        .NUM_WR_PORTS (NWR),
        .BYPASS       (1'b1),
        .RESET_PC     (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rd_addr        (rd_addr),
        .rd_user        (rd_user),
        .rd_data        (rd_data),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_user        (wr_user),
        .wr_data        (wr_data),
        .pc_inc         (pc_inc),
        .pc_o           (pc_o),
        .cpsr_wr_en     (cpsr_wr_en),
        .cpsr_wr_mask   (cpsr_wr_mask),
        .cpsr_wr_data   (cpsr_wr_data),
        .flags_wr_en    (flags_wr_en),
        .flags_i        (flags_i),
        .spsr_wr_en     (spsr_wr_en),
        .spsr_wr_mask   (spsr_wr_mask),
        .spsr_wr_data   (spsr_wr_data),
        .spsr_restore   (spsr_restore),
        .exc_req        (exc_req),
        .exc_mode       (exc_mode),
        .exc_vector     (exc_vector),
        .exc_lr         (exc_lr),
        .exc_set_f      (exc_set_f),
        .cpsr_o         (cpsr_o),
        .spsr_o         (spsr_o),
        .illegal_mode_o (illegal_mode_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_req();
        wr_en        = '0;
        wr_user      = '0;
        pc_inc       = 1'b0;
        cpsr_wr_en   = 1'b0;
        flags_wr_en  = 1'b0;
        spsr_wr_en   = 1'b0;
        spsr_restore = 1'b0;
        exc_req      = 1'b0;
        exc_set_f    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        clear_req();
    endtask

    task automatic rdchk(input string tag, input int p, input logic [3:0] a,
                         input logic u, input logic [31:0] exp);
        rd_addr[p*4 +: 4] = a;
        rd_user[p]        = u;
        #1;
        check(tag, rd_data[p*32 +: 32], exp);
    endtask

    task automatic wport(input int p, input logic [3:0] a, input logic [31:0] d);
        wr_en[p]          = 1'b1;
        wr_addr[p*4 +: 4] = a;
        wr_data[p*32 +: 32] = d;
    endtask

    task automatic msr(input logic [3:0] mask, input logic [31:0] d);
        cpsr_wr_en   = 1'b1;
        cpsr_wr_mask = mask;
        cpsr_wr_data = d;
    endtask

    task automatic exc(input logic [4:0] m, input logic [31:0] vec,
                       input logic [31:0] lr, input logic set_f);
        exc_req    = 1'b1;
        exc_mode   = m;
        exc_vector = vec;
        exc_lr     = lr;
        exc_set_f  = set_f;
    endtask

    initial begin
        rd_addr = '0; rd_user = '0; wr_addr = '0; wr_data = '0;
        cpsr_wr_mask = '0; cpsr_wr_data = '0; flags_i = '0;
        spsr_wr_mask = '0; spsr_wr_data = '0;
        exc_mode = '0; exc_vector = '0; exc_lr = '0;
        clear_req();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        check("rst_cpsr", cpsr_o, 32'h0000_00D3);
        check("rst_pc", pc_o, RST_PC);
        check("rst_spsr", spsr_o, 32'h0);
        check("rst_illegal", 32'(illegal_mode_o), 32'h0);
        for (int i = 0; i < 15; i++) rdchk($sformatf("rst_r%0d", i), i % 3, 4'(i), 1'b0, 32'h0);

        pc_inc = 1'b1;
        step();
        check("pc_inc_arm", pc_o, 32'h0000_0104);

        // SVC r13 vs user r13
        wport(0, 4'd13, 32'h0000_1000);
        step();
        rdchk("svc_r13", 0, 4'd13, 1'b0, 32'h0000_1000);
        msr(4'b0001, 32'h0000_0010);
        step();
        check("to_usr_cpsr", cpsr_o, 32'h0000_0010);
        rdchk("usr_r13", 0, 4'd13, 1'b0, 32'h0);
        exc(5'b10011, 32'h0000_0008, 32'h0000_0300, 1'b0);
        step();
        check("svc_exc_cpsr", cpsr_o, 32'h0000_0093);
        check("svc_exc_spsr", spsr_o, 32'h0000_0010);
        check("svc_exc_pc", pc_o, 32'h0000_0008);
        rdchk("svc_r13_back", 0, 4'd13, 1'b0, 32'h0000_1000);
        rdchk("svc_r14", 1, 4'd14, 1'b0, 32'h0000_0300);

        // IRQ entry from USR with flags set, then restore
        msr(4'b1001, 32'hF000_0010);
        step();
        check("usr_flags_cpsr", cpsr_o, 32'hF000_0010);
        exc(5'b10010, 32'h0000_0018, 32'h0000_0204, 1'b0);
        step();
        check("irq_cpsr", cpsr_o, 32'hF000_0092);
        check("irq_spsr", spsr_o, 32'hF000_0010);
        check("irq_pc", pc_o, 32'h0000_0018);
        rdchk("irq_r14", 0, 4'd14, 1'b0, 32'h0000_0204);
        spsr_restore = 1'b1;
        step();
        check("restore_cpsr", cpsr_o, 32'hF000_0010);

        // FIQ banking and bypass
        exc(5'b10001, 32'h0000_001C, 32'h0000_0040, 1'b1);
        step();
        check("fiq_cpsr", cpsr_o, 32'hF000_00D1);
        check("fiq_spsr", spsr_o, 32'hF000_0010);
        wport(1, 4'd8, 32'h0000_00AA);
        rdchk("fiq_r8_bypass", 0, 4'd8, 1'b0, 32'h0000_00AA);
        rdchk("fiq_r8_user_bypass", 1, 4'd8, 1'b1, 32'h0);
        step();
        rdchk("fiq_r8", 0, 4'd8, 1'b0, 32'h0000_00AA);
        rdchk("fiq_r8_user", 1, 4'd8, 1'b1, 32'h0);

        // Write-port collision
        wport(0, 4'd3, 32'h1);
        wport(1, 4'd3, 32'h2);
        rdchk("r3_bypass_prio", 2, 4'd3, 1'b0, 32'h2);
        step();
        rdchk("r3_prio", 2, 4'd3, 1'b0, 32'h2);

        // Exception entry beats a port write to the same banked LR
        msr(4'b0001, 32'h0000_00D2);
        step();
        check("to_irq_cpsr", cpsr_o, 32'hF000_00D2);
        wport(0, 4'd14, 32'h0000_5555);
        exc(5'b10010, 32'h0000_0018, 32'h0000_0208, 1'b0);
        step();
        rdchk("irq_r14_exc_wins", 0, 4'd14, 1'b0, 32'h0000_0208);
        check("irq_reentry_spsr", spsr_o, 32'hF000_00D2);
        check("irq_reentry_pc", pc_o, 32'h0000_0018);

        // Invalid mode via MSR
        msr(4'b0001, 32'h0000_0000);
        step();
        check("illegal_cpsr", cpsr_o, 32'hF000_0012);
        check("illegal_pulse", 32'(illegal_mode_o), 32'h1);
        step();
        check("illegal_clear", 32'(illegal_mode_o), 32'h0);

        // Thumb PC increment
        msr(4'b0001, 32'h0000_0032);
        step();
        check("thumb_cpsr", cpsr_o, 32'hF000_0032);
        pc_inc = 1'b1;
        step();
        check("pc_inc_thumb", pc_o, 32'h0000_001A);

        // USR restrictions
        msr(4'b0001, 32'h0000_0010);
        step();
        flags_wr_en = 1'b1;
        flags_i     = 4'b0000;
        step();
        check("usr_flags0", cpsr_o, 32'h0000_0010);
        msr(4'b1001, 32'hF000_00D3);
        step();
        check("usr_msr_fc", cpsr_o, 32'hF000_0010);
        msr(4'b1000, 32'h3000_0000);
        flags_wr_en = 1'b1;
        flags_i     = 4'b0101;
        step();
        check("flags_over_msr", cpsr_o, 32'h5000_0010);
        spsr_restore = 1'b1;
        step();
        check("usr_restore_ignored", cpsr_o, 32'h5000_0010);
        exc(5'b11111, 32'h0000_0099, 32'h0000_0077, 1'b0);
        step();
        check("sys_exc_cpsr", cpsr_o, 32'h5000_0010);
        check("sys_exc_pc", pc_o, 32'h0000_001A);
        check("sys_exc_pulse", 32'(illegal_mode_o), 32'h1);

        // Reset discards same-cycle requests
        rst = 1'b1;
        wport(0, 4'd0, 32'h0000_DEAD);
        exc(5'b10010, 32'h0000_0018, 32'h0000_0123, 1'b0);
        step();
        rst = 1'b0;
        check("rst2_cpsr", cpsr_o, 32'h0000_00D3);
        check("rst2_pc", pc_o, RST_PC);
        check("rst2_illegal", 32'(illegal_mode_o), 32'h0);
        rdchk("rst2_r0", 0, 4'd0, 1'b0, 32'h0);
        rdchk("rst2_r3", 1, 4'd3, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
